mem_write_monitor: RTL and testbench

Synthesizable, parametrised pass/fail monitor for the multicycle RISC-V cores. It watches the data-memory write port of up to NUM_CORES cores and detects the completion signature, a write of PASS_DATA to PASS_ADDR. It enforces a cycle timeout and buffers observed writes in a log FIFO for readout. It sits beside Risc_top in simulation and FPGA builds, replacing ad-hoc testbench checks with a reusable block that has registered status outputs.

---
 rtl/mem_write_monitor_pkg.sv | 33 +++
 rtl/mem_write_monitor_log_fifo.sv | 54 +++++
 rtl/mem_write_monitor.sv | 167 ++++++++++++++++
 tb/tb_mem_write_monitor.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_write_monitor_pkg.sv
// Shared types for the memory-write pass/fail monitor.
// Latency: n/a (types and constant helpers only).
// Backpressure: n/a.
// Contents: mon_status_t state/status encoding, log entry field-width helper,
//           terminal-state predicate.
package riscv_mon_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RUN     = 3'd1,
    PASS    = 3'd2,
    FAIL    = 3'd3,
    TIMEOUT = 3'd4
  } mon_status_t;

  // Width of a core index; a single-core build still carries a 1-bit field.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic is_terminal(input mon_status_t s);
    return (s == PASS) || (s == FAIL) || (s == TIMEOUT);
  endfunction

  // Log entry layout {core, addr, data} at the default build widths. The top
  // level rebuilds the same layout at its own parameter widths.
  typedef struct packed {
    logic [0:0]  core;
    logic [31:0] addr;
    logic [31:0] data;
  } log_entry_t;

endpackage

// File: rtl/mem_write_monitor_log_fifo.sv
// Synchronous FIFO holding observed writes for readout.
// Latency: push at edge N is visible at the head after edge N.
// Backpressure: push is refused when full unless a pop happens in the same cycle.
// Ports: clk, reset (sync, active low); push/push_data in; pop in;
//        head (zero when empty), full, empty out.
module mon_log_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // One extra wrap bit distinguishes full from empty when the indices match.
  logic [PTR_W:0]   rd_ptr;
  logic [PTR_W:0]   wr_ptr;
  logic             pop_do;
  logic             push_do;

  assign empty   = (rd_ptr == wr_ptr);
  assign full    = (rd_ptr[PTR_W] != wr_ptr[PTR_W]) &&
                   (rd_ptr[PTR_W-1:0] == wr_ptr[PTR_W-1:0]);
  assign pop_do  = pop && !empty;
  // When full, a same-cycle pop frees the slot being written.
  assign push_do = push && (!full || pop_do);

  assign head = empty ? '0 : mem[rd_ptr[PTR_W-1:0]];

  always_ff @(posedge clk) begin
    if (push_do) begin
      mem[wr_ptr[PTR_W-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (pop_do)  rd_ptr <= rd_ptr + 1'b1;
      if (push_do) wr_ptr <= wr_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/mem_write_monitor.sv
// Pass/fail monitor on the data-memory write ports of NUM_CORES cores.
// Latency: status/done/fail_core one edge after the qualifying write; log head one edge after push.
// Backpressure: log_ready pops the head; writes that cannot be logged bump log_dropped.
// Ports: clk, reset (sync, active low), enable; per-core mem_write/data_adr/write_data;
//        status, done, cycle_count, fail_core; log_valid/log_ready/log_core/log_addr/log_data;
//        log_dropped.
module mem_write_monitor
  import riscv_mon_pkg::*;
#(
  parameter int                 NUM_CORES      = 2,
  parameter int                 ADDR_W         = 32,
  parameter int                 DATA_W         = 32,
  parameter logic [ADDR_W-1:0]  PASS_ADDR      = ADDR_W'(50),
  parameter logic [DATA_W-1:0]  PASS_DATA      = DATA_W'(4140),
  parameter int                 TIMEOUT_CYCLES = 2000,
  parameter int                 LOG_DEPTH      = 8,
  localparam int                CORE_W         = idx_w(NUM_CORES),
  localparam int                CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic [NUM_CORES-1:0]        mem_write,
  input  logic [NUM_CORES*ADDR_W-1:0] data_adr,
  input  logic [NUM_CORES*DATA_W-1:0] write_data,
  output mon_status_t                 status,
  output logic                        done,
  output logic [CNT_W-1:0]            cycle_count,
  output logic [CORE_W-1:0]           fail_core,
  output logic                        log_valid,
  input  logic                        log_ready,
  output logic [CORE_W-1:0]           log_core,
  output logic [ADDR_W-1:0]           log_addr,
  output logic [DATA_W-1:0]           log_data,
  output logic [7:0]                  log_dropped
);

  typedef struct packed {
    logic [CORE_W-1:0] core;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  mon_status_t       state, state_n;
  logic [CNT_W-1:0]  cnt_n;
  logic [CORE_W-1:0] fail_core_n;
  logic [7:0]        dropped_n;

  logic              any_fail;
  logic              any_pass;
  logic              any_wr;
  logic [CORE_W-1:0] fail_idx;
  entry_t            push_entry;
  logic [31:0]       wr_cnt;
  logic [31:0]       drop_inc;
  logic [31:0]       drop_sum;

  entry_t            head;
  logic              fifo_full;
  logic              fifo_empty;

  // Write decode and priority encoders: lowest index wins both the fail
  // report and the single log slot per cycle.
  always_comb begin
    any_fail   = 1'b0;
    any_pass   = 1'b0;
    any_wr     = 1'b0;
    fail_idx   = '0;
    push_entry = '0;
    wr_cnt     = '0;
    if (state == RUN) begin
      for (int i = NUM_CORES - 1; i >= 0; i--) begin
        if (mem_write[i]) begin
          any_wr     = 1'b1;
          wr_cnt     = wr_cnt + 32'd1;
          push_entry = '{core: CORE_W'(i),
                         addr: data_adr[i*ADDR_W +: ADDR_W],
                         data: write_data[i*DATA_W +: DATA_W]};
          if (data_adr[i*ADDR_W +: ADDR_W] == PASS_ADDR) begin
            if (write_data[i*DATA_W +: DATA_W] == PASS_DATA) begin
              any_pass = 1'b1;
            end else begin
              any_fail = 1'b1;
              fail_idx = CORE_W'(i);
            end
          end
        end
      end
    end
  end

  // Losers of the log arbitration, plus the winner if the FIFO is full and
  // not being drained this cycle.
  always_comb begin
    drop_inc = (wr_cnt > 32'd0) ? (wr_cnt - 32'd1) : 32'd0;
    if (any_wr && fifo_full && !log_ready) begin
      drop_inc = drop_inc + 32'd1;
    end
    drop_sum  = {24'd0, log_dropped} + drop_inc;
    dropped_n = (drop_sum > 32'd255) ? 8'hFF : drop_sum[7:0];
  end

  // Next state. cycle_count counts completed RUN cycles, so the edge that
  // leaves RUN still increments it and the frozen value is the RUN length.
  always_comb begin
    state_n     = state;
    cnt_n       = cycle_count;
    fail_core_n = fail_core;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (enable) state_n = RUN;
      end
      RUN: begin
        cnt_n = cycle_count + 1'b1;
        if (any_fail) begin
          state_n     = FAIL;
          fail_core_n = fail_idx;
        end else if (any_pass) begin
          state_n = PASS;
        end else if (cycle_count == CNT_LAST) begin
          state_n = TIMEOUT;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      done        <= 1'b0;
      cycle_count <= '0;
      fail_core   <= '0;
      log_dropped <= '0;
    end else begin
      state       <= state_n;
      done        <= is_terminal(state_n);
      cycle_count <= cnt_n;
      fail_core   <= fail_core_n;
      log_dropped <= dropped_n;
    end
  end

  mon_log_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (LOG_DEPTH)
  ) u_log (
    .clk       (clk),
    .reset     (reset),
    .push      (any_wr),
    .push_data (push_entry),
    .pop       (log_ready),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign status    = state;
  assign log_valid = !fifo_empty;
  assign log_core  = head.core;
  assign log_addr  = head.addr;
  assign log_data  = head.data;

endmodule

// File: tb/tb_mem_write_monitor.sv
// Directed bench for mem_write_monitor with a scoreboard of expected log entries.
// Build: NUM_CORES=2, TIMEOUT_CYCLES=20, LOG_DEPTH=4, default addresses/data.
module tb_mem_write_monitor;
  import riscv_mon_pkg::*;

  localparam int NC = 2;
  localparam int AW = 32;
  localparam int DW = 32;

  typedef struct packed {
    logic [0:0]  core;
    logic [31:0] addr;
    logic [31:0] data;
  } ent_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              enable;
  logic [NC-1:0]     mem_write;
  logic [NC*AW-1:0]  data_adr;
  logic [NC*DW-1:0]  write_data;
  mon_status_t       status;
  logic              done;
  logic [4:0]        cycle_count;
  logic [0:0]        fail_core;
  logic              log_valid;
  logic              log_ready;
  logic [0:0]        log_core;
  logic [AW-1:0]     log_addr;
  logic [DW-1:0]     log_data;
  logic [7:0]        log_dropped;

  int   n_checks = 0;
  int   n_fail   = 0;
  ent_t sb[$];

  always #5 clk = ~clk;

  mem_write_monitor #(
    .NUM_CORES(NC), .ADDR_W(AW), .DATA_W(DW),
    .TIMEOUT_CYCLES(20), .LOG_DEPTH(4)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .mem_write(mem_write), .data_adr(data_adr), .write_data(write_data),
    .status(status), .done(done), .cycle_count(cycle_count), .fail_core(fail_core),
    .log_valid(log_valid), .log_ready(log_ready), .log_core(log_core),
    .log_addr(log_addr), .log_data(log_data), .log_dropped(log_dropped)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_wr();
    mem_write  = '0;
    data_adr   = '0;
    write_data = '0;
  endtask

  task automatic set_wr(input int core, input logic [31:0] a, input logic [31:0] d);
    mem_write[core]          = 1'b1;
    data_adr[core*AW +: AW]  = a;
    write_data[core*DW +: DW] = d;
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    enable    = 1'b0;
    log_ready = 1'b0;
    clear_wr();
    tick();
    sb.delete();
    reset = 1'b1;
  endtask

  task automatic start_run();
    enable = 1'b1;
    tick();
    enable = 1'b0;
  endtask

  // Compare the head against the scoreboard each cycle while popping.
  task automatic drain(input string tag);
    ent_t e;
    log_ready = 1'b1;
    for (int c = 0; c < 40 && (sb.size() > 0 || log_valid); c++) begin
      if (log_valid) begin
        if (sb.size() == 0) begin
          chk({tag, "_extra"}, 64'(log_valid), 64'd0);
        end else begin
          e = sb.pop_front();
          chk({tag, "_core"}, 64'(log_core), 64'(e.core));
          chk({tag, "_addr"}, 64'(log_addr), 64'(e.addr));
          chk({tag, "_data"}, 64'(log_data), 64'(e.data));
        end
      end
      tick();
    end
    log_ready = 1'b0;
    chk({tag, "_empty"}, 64'(log_valid), 64'd0);
    chk({tag, "_sb_left"}, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    do_reset();
    // Reset values
    chk("rst_status", 64'(status), 64'(IDLE));
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_count", 64'(cycle_count), 64'd0);
    chk("rst_fail_core", 64'(fail_core), 64'd0);
    chk("rst_log_valid", 64'(log_valid), 64'd0);
    chk("rst_log_addr", 64'(log_addr), 64'd0);
    chk("rst_dropped", 64'(log_dropped), 64'd0);

    // PASS in the 10th RUN cycle
    start_run();
    chk("run_status", 64'(status), 64'(RUN));
    for (int i = 0; i < 9; i++) tick();
    set_wr(0, 32'd50, 32'd4140);
    sb.push_back('{core: 1'b0, addr: 32'd50, data: 32'd4140});
    tick();
    clear_wr();
    chk("pass_status", 64'(status), 64'(PASS));
    chk("pass_done", 64'(done), 64'd1);
    chk("pass_count", 64'(cycle_count), 64'd10);
    chk("pass_log_valid", 64'(log_valid), 64'd1);
    set_wr(1, 32'd50, 32'd7);       // ignored in a terminal state
    tick();
    clear_wr();
    chk("pass_sticky", 64'(status), 64'(PASS));
    chk("pass_count_frozen", 64'(cycle_count), 64'd10);
    drain("pass_log");

    // FAIL beats PASS in the same cycle; core 0 wins the log slot
    do_reset();
    start_run();
    set_wr(0, 32'd50, 32'd4140);
    set_wr(1, 32'd50, 32'd4139);
    sb.push_back('{core: 1'b0, addr: 32'd50, data: 32'd4140});
    tick();
    clear_wr();
    chk("fail_status", 64'(status), 64'(FAIL));
    chk("fail_core", 64'(fail_core), 64'd1);
    chk("fail_done", 64'(done), 64'd1);
    chk("fail_dropped", 64'(log_dropped), 64'd1);
    chk("fail_count", 64'(cycle_count), 64'd1);
    drain("fail_log");

    // TIMEOUT after exactly 20 RUN cycles
    do_reset();
    start_run();
    for (int i = 0; i < 19; i++) tick();
    chk("to_still_run", 64'(status), 64'(RUN));
    chk("to_count19", 64'(cycle_count), 64'd19);
    tick();
    chk("to_status", 64'(status), 64'(TIMEOUT));
    chk("to_count", 64'(cycle_count), 64'd20);
    chk("to_done", 64'(done), 64'd1);
    set_wr(0, 32'd50, 32'd4140);
    tick();
    clear_wr();
    chk("to_sticky", 64'(status), 64'(TIMEOUT));
    chk("to_no_log", 64'(log_valid), 64'd0);
    chk("to_no_drop", 64'(log_dropped), 64'd0);

    // Overfill the 4-entry log, then pop+push on a full FIFO
    do_reset();
    start_run();
    for (int i = 0; i < 6; i++) begin
      set_wr(0, 32'd100, 32'(i));
      if (i < 4) sb.push_back('{core: 1'b0, addr: 32'd100, data: 32'(i)});
      tick();
    end
    clear_wr();
    chk("full_valid", 64'(log_valid), 64'd1);
    chk("full_dropped", 64'(log_dropped), 64'd2);
    chk("full_head", 64'(log_data), 64'd0);
    chk("full_head_hold", 64'(log_addr), 64'd100);
    log_ready = 1'b1;
    chk("pp_head", 64'(log_data), 64'(sb[0].data));
    void'(sb.pop_front());
    set_wr(0, 32'd100, 32'h77);
    sb.push_back('{core: 1'b0, addr: 32'd100, data: 32'h77});
    tick();
    clear_wr();
    log_ready = 1'b0;
    chk("pp_dropped", 64'(log_dropped), 64'd2);
    chk("pp_next_head", 64'(log_data), 64'd1);
    drain("full_log");

    // Reset in the middle of RUN with three entries logged
    do_reset();
    start_run();
    for (int i = 0; i < 3; i++) begin
      set_wr(1, 32'd200 + 32'(i), 32'(i));
      tick();
    end
    clear_wr();
    chk("mid_valid", 64'(log_valid), 64'd1);
    reset = 1'b0;
    tick();
    chk("mid_status", 64'(status), 64'(IDLE));
    chk("mid_count", 64'(cycle_count), 64'd0);
    chk("mid_log_valid", 64'(log_valid), 64'd0);
    chk("mid_log_core", 64'(log_core), 64'd0);
    chk("mid_log_data", 64'(log_data), 64'd0);
    chk("mid_done", 64'(done), 64'd0);
    reset = 1'b1;
    start_run();
    chk("restart_status", 64'(status), 64'(RUN));
    chk("restart_count0", 64'(cycle_count), 64'd0);
    tick();
    chk("restart_count1", 64'(cycle_count), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
